// File: rtl/spi_master_mmio_if.sv
// rtl/spi_master_mmio_if.sv - CPU data-port bundle between the core and the SPI master
interface spi_master_mmio_if #(
  parameter int W_CPU = 32
);
  logic             bus_wen;
  logic             bus_ren;
  logic [W_CPU-1:0] bus_addr;
  logic [W_CPU-1:0] bus_wdata;
  logic [W_CPU-1:0] bus_rdata;
  logic             bus_hit;

  modport master (
    output bus_wen, bus_ren, bus_addr, bus_wdata,
    input  bus_rdata, bus_hit
  );

  modport slave (
    input  bus_wen, bus_ren, bus_addr, bus_wdata,
    output bus_rdata, bus_hit
  );
endinterface

// File: rtl/spi_master_mmio.sv
// rtl/spi_master_mmio.sv - memory-mapped single-byte SPI master, mode 0, MSB first
module spi_master_mmio #(
  parameter int               W_CPU     = 32,
  parameter logic [W_CPU-1:0] BASE_ADDR = 32'h0000_FF00,
  parameter logic [15:0]      DIV_RST   = 16'd4
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_mmio_if.slave bus,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t      state, state_next;
  logic [7:0]  shift_reg;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [15:0] clkdiv;
  logic [15:0] div_lat;
  logic [15:0] div_cnt;
  logic [3:0]  half_cnt;
  logic        rx_valid, overrun, tx_drop;

  logic        hit, wr, rd, tx_wr, busy, wrap;
  logic        start, toggle, done;
  logic [1:0]  off;
  logic        unused_ok;

  assign hit   = (bus.bus_addr[W_CPU-1:4] == BASE_ADDR[W_CPU-1:4]);
  assign off   = bus.bus_addr[3:2];
  assign wr    = bus.bus_wen & hit;
  assign rd    = bus.bus_ren & hit;
  assign tx_wr = wr && (off == 2'd0);
  assign busy  = (state != IDLE);
  assign wrap  = (div_cnt == div_lat - 16'd1);

  assign bus.bus_hit = hit;
  assign spi_cs_n    = ~busy;
  assign irq         = rx_valid;
  assign unused_ok   = ^{bus.bus_wdata[W_CPU-1:16], bus.bus_addr[1:0]};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus the one-cycle strobes that drive the datapath
  always_comb begin
    state_next = state;
    start      = 1'b0;
    toggle     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (tx_wr) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (wrap) begin
          toggle = 1'b1;
          if (half_cnt == 4'd15) state_next = HOLD;
        end
      end
      HOLD: begin
        if (wrap) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift engine: divider, SCLK generation, MOSI drive and MISO sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= 8'd0;
      rx_shift  <= 8'd0;
      div_lat   <= DIV_RST;
      div_cnt   <= 16'd0;
      half_cnt  <= 4'd0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
    end else if (start) begin
      shift_reg <= bus.bus_wdata[7:0];
      div_lat   <= clkdiv;
      div_cnt   <= 16'd0;
      half_cnt  <= 4'd0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= bus.bus_wdata[7];
    end else if (busy) begin
      div_cnt <= wrap ? 16'd0 : div_cnt + 16'd1;
      if (toggle) begin
        spi_sclk <= ~spi_sclk;
        half_cnt <= half_cnt + 4'd1;
        if (!half_cnt[0]) begin
          rx_shift <= {rx_shift[6:0], spi_miso};
        end else begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          spi_mosi  <= shift_reg[6];
        end
      end
    end
  end

  // Software-visible registers; sets are placed after clears so a set wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      tx_drop  <= 1'b0;
      clkdiv   <= DIV_RST;
    end else begin
      if (rd && off == 2'd1) rx_valid <= 1'b0;
      if (wr && off == 2'd2 && bus.bus_wdata[2]) overrun <= 1'b0;
      if (wr && off == 2'd2 && bus.bus_wdata[3]) tx_drop <= 1'b0;
      if (wr && off == 2'd3)
        clkdiv <= (bus.bus_wdata[15:0] == 16'd0) ? 16'd1 : bus.bus_wdata[15:0];
      if (tx_wr && busy) tx_drop <= 1'b1;
      if (done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid) overrun <= 1'b1;
      end
    end
  end

  // Combinational load data so single-cycle loads complete in place
  always_comb begin
    bus.bus_rdata = '0;
    if (hit) begin
      case (off)
        2'd1:    bus.bus_rdata[7:0]  = rx_byte;
        2'd2:    bus.bus_rdata[3:0]  = {tx_drop, overrun, rx_valid, busy};
        2'd3:    bus.bus_rdata[15:0] = clkdiv;
        default: bus.bus_rdata       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mmio.sv
// tb/tb_spi_master_mmio.sv - scoreboard bench for the memory-mapped SPI master
`timescale 1ns/1ps
module tb_spi_master_mmio;

  localparam int          W     = 32;
  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_RX  = BASE + 32'd4;
  localparam logic [31:0] A_ST  = BASE + 32'd8;
  localparam logic [31:0] A_DIV = BASE + 32'd12;
  localparam time         TCLK  = 10;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk, spi_mosi, spi_miso, spi_cs_n, irq;
  logic [1:0] miso_mode;

  spi_master_mmio_if #(.W_CPU(W)) bus ();

  spi_master_mmio #(
    .W_CPU    (W),
    .BASE_ADDR(BASE),
    .DIV_RST  (16'd4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // slave model: 0 loopback, 1 drives ones, 2 drives zeros
  assign spi_miso = (miso_mode == 2'd0) ? spi_mosi : (miso_mode == 2'd1);

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // SPI line monitor: phase widths, MOSI setup and captured byte
  int         mon_div = 4;
  bit         mon_en  = 1'b0;
  time        t_mosi, t_rise, t_fall, t_cs_rise, t_cs_fall, t_start;
  logic [7:0] mosi_cap;
  int         bit_cnt;

  always @(spi_mosi) t_mosi = $time;
  always @(posedge spi_cs_n) t_cs_rise = $time;
  always @(negedge spi_cs_n) begin
    t_cs_fall = $time;
    t_fall    = $time;
    bit_cnt   = 0;
  end

  always @(posedge spi_sclk) begin
    if (mon_en) begin
      chk("sclk_low_phase", 32'($time - t_fall), 32'(mon_div * TCLK));
      chk("mosi_setup", 32'(($time - t_mosi) >= mon_div * TCLK), 32'd1);
      mosi_cap = {mosi_cap[6:0], spi_mosi};
      bit_cnt++;
      t_rise = $time;
    end
  end

  always @(negedge spi_sclk) begin
    if (mon_en) begin
      chk("sclk_high_phase", 32'($time - t_rise), 32'(mon_div * TCLK));
      t_fall = $time;
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    bus.bus_wen   = 1'b1;
    @(posedge clk);
    #1 bus.bus_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.bus_addr = a;
    bus.bus_ren  = 1'b1;
    #1 d = bus.bus_rdata;
    @(posedge clk);
    #1 bus.bus_ren = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.bus_addr = a;
    #1 d = bus.bus_rdata;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx, input int div);
    exp_q.push_back('{tx: tx, rx: rx, lat: 17 * div});
    mon_div = div;
    bus_wr(A_TX, {24'd0, tx});
    t_start = $time;
    chk("cs_low_after_start", {31'd0, spi_cs_n}, 32'd0);
  endtask

  task automatic finish_xfer();
    int          n;
    exp_t        e;
    logic [31:0] d;
    n = 0;
    while (spi_cs_n !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) chk("xfer_timeout", 32'd0, 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("latency", 32'(($time - t_start) / TCLK), 32'(e.lat));
      chk("mosi_byte", {24'd0, mosi_cap}, {24'd0, e.tx});
      chk("bit_count", 32'(bit_cnt), 32'd8);
      peek(A_RX, d);
      chk("rxdata", d, {24'd0, e.rx});
      chk("irq_after_done", {31'd0, irq}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] d;
    bus.bus_wen   = 1'b0;
    bus.bus_ren   = 1'b0;
    bus.bus_addr  = 32'd0;
    bus.bus_wdata = 32'd0;
    miso_mode     = 2'd0;

    #2 rst = 1'b0;
    #10;
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    peek(A_ST, d);  chk("rst_status", d, 32'd0);
    peek(A_DIV, d); chk("rst_clkdiv", d, 32'd4);
    peek(A_RX, d);  chk("rst_rxdata", d, 32'd0);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // asynchronous reset part-way through a transfer (after 7 SCLK toggles)
    mon_div = 4;
    bus_wr(A_TX, 32'h5A);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("sclk_high_before_rst", {31'd0, spi_sclk}, 32'd1);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("midrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("midrst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("midrst_mosi", {31'd0, spi_mosi}, 32'd0);
    peek(A_ST, d);  chk("midrst_status", d, 32'd0);
    peek(A_DIV, d); chk("midrst_clkdiv", d, 32'd4);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // loopback 0xA5 at CLKDIV=2
    bus_wr(A_DIV, 32'd2);
    start_xfer(8'hA5, 8'hA5, 2);
    finish_xfer();
    peek(A_ST, d); chk("status_rx_valid", d, 32'h2);
    bus_rd(A_RX, d); chk("rxdata_read", d, 32'hA5);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // TXDATA write while busy is dropped
    start_xfer(8'h96, 8'h96, 2);
    repeat (3) @(posedge clk);
    bus_wr(A_TX, 32'h3C);
    peek(A_ST, d); chk("status_busy_drop", d, 32'h9);
    finish_xfer();
    peek(A_ST, d); chk("status_drop_done", d, 32'hA);
    bus_wr(A_ST, 32'h8);
    peek(A_ST, d); chk("status_drop_clr", d, 32'h2);
    bus_rd(A_RX, d); chk("rxdata_96", d, 32'h96);

    // overrun: two completions without a read
    miso_mode = 2'd1;
    start_xfer(8'h12, 8'hFF, 2);
    finish_xfer();
    miso_mode = 2'd2;
    start_xfer(8'h34, 8'h00, 2);
    finish_xfer();
    peek(A_ST, d); chk("status_overrun", d, 32'h6);
    bus_rd(A_RX, d); chk("rxdata_overwritten", d, 32'h0);
    chk("irq_after_read", {31'd0, irq}, 32'd0);
    peek(A_ST, d); chk("status_ovr_only", d, 32'h4);
    bus_wr(A_ST, 32'h4);
    peek(A_ST, d); chk("status_ovr_clr", d, 32'h0);
    miso_mode = 2'd0;

    // CLKDIV=0 stores 1; divider change mid-transfer applies to the next one
    bus_wr(A_DIV, 32'd0);
    peek(A_DIV, d); chk("clkdiv_zero_is_one", d, 32'd1);
    start_xfer(8'hFF, 8'hFF, 1);
    bus_wr(A_DIV, 32'd3);
    finish_xfer();
    peek(A_DIV, d); chk("clkdiv_new", d, 32'd3);

    // back-to-back transfer, CS high for exactly one clock
    start_xfer(8'h81, 8'h81, 3);
    chk("cs_gap", 32'(t_cs_fall - t_cs_rise), 32'(TCLK));
    finish_xfer();
    peek(A_ST, d); chk("status_b2b", d, 32'h6);
    bus_rd(A_RX, d); chk("rxdata_81", d, 32'h81);
    bus_wr(A_ST, 32'h4);

    // simultaneous store and load to CLKDIV
    @(negedge clk);
    bus.bus_addr  = A_DIV;
    bus.bus_wdata = 32'd2;
    bus.bus_wen   = 1'b1;
    bus.bus_ren   = 1'b1;
    #1 chk("wen_ren_rdata", bus.bus_rdata, 32'd3);
    @(posedge clk);
    #1;
    bus.bus_wen = 1'b0;
    bus.bus_ren = 1'b0;
    peek(A_DIV, d); chk("wen_ren_written", d, 32'd2);

    // access just past the window
    @(negedge clk);
    bus.bus_addr  = BASE + 32'h10;
    bus.bus_wdata = 32'h55;
    bus.bus_wen   = 1'b1;
    bus.bus_ren   = 1'b1;
    #1;
    chk("miss_hit", {31'd0, bus.bus_hit}, 32'd0);
    chk("miss_rdata", bus.bus_rdata, 32'd0);
    @(posedge clk);
    #1;
    bus.bus_wen = 1'b0;
    bus.bus_ren = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("miss_no_xfer", {31'd0, spi_cs_n}, 32'd1);
    peek(A_ST, d); chk("miss_status", d, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    chk("watchdog", 32'd0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
